// File: rtl/inst_mem_ld.sv
// Instruction memory with a boot-time load port and a pipelined fetch port.
// After reset the block is in LOAD: the loader writes words through the ld_*
// port until it raises ld_done. From then on the block is in RUN: the array is
// read-only and serves one fetch per cycle with a latency of 1 or 2 cycles.
// Out-of-range fetches return NOP and raise addr_err at the normal latency.
module inst_mem_ld #(
  parameter int                DATA_W = 16,
  parameter int                ADDR_W = 16,
  parameter int                DEPTH  = 256,
  parameter int                RD_LAT = 1,   // 2 adds an output register; anything else behaves as 1
  parameter logic [DATA_W-1:0] NOP    = '0
) (
  input  logic              clk,
  input  logic              rst,
  // load port
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  output logic [ADDR_W:0]   ld_count,
  output logic              ld_err,
  output logic              run,
  // fetch port
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              addr_err
);

  localparam int            IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so that DEPTH == 2**ADDR_W is representable in the compare.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state;

  logic [DATA_W-1:0] mem [DEPTH];

  // Range checks use the full address so aliasing high bits are caught.
  logic ld_in_range;
  logic fetch_in_range;
  logic mem_we;
  logic fetch_acc;

  assign ld_in_range    = ({1'b0, ld_addr}   < DEPTH_C);
  assign fetch_in_range = ({1'b0, inst_addr} < DEPTH_C);
  assign mem_we         = !rst && (state == ST_LOAD) && ld_valid && ld_in_range;
  assign fetch_acc      = (state == ST_RUN) && inst_req;

  // Mode FSM plus the load bookkeeping registers (count, sticky error, run flag).
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_LOAD;
      run      <= 1'b0;
      ld_count <= '0;
      ld_err   <= 1'b0;
    end else if (state == ST_LOAD) begin
      if (ld_valid) begin
        if (ld_in_range) begin
          if (ld_count != CNT_MAX) ld_count <= ld_count + 1'b1;
        end else begin
          ld_err <= 1'b1;
        end
      end
      // A write in the same cycle as ld_done still lands, since mem_we is
      // qualified by the current state, not the next one.
      if (ld_done) begin
        state <= ST_RUN;
        run   <= 1'b1;
      end
    end
  end

  // Array write port, active only while loading.
  // NOTE: the array has no reset on purpose: contents survive rst, and a reset
  // would prevent mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ld_addr[IDX_W-1:0]] <= ld_data;
  end

  // First pipeline stage: registered array read (or NOP for out-of-range).
  logic              s1_valid;
  logic              s1_err;
  logic [DATA_W-1:0] s1_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else if (fetch_acc) begin
      s1_valid <= 1'b1;
      s1_err   <= !fetch_in_range;
      s1_data  <= fetch_in_range ? mem[inst_addr[IDX_W-1:0]] : NOP;
    end else begin
      // Data holds the last returned word; the error flag only lives with valid.
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              s2_valid;
      logic              s2_err;
      logic [DATA_W-1:0] s2_data;

      // Second pipeline stage: plain output register behind the array read.
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_err   <= 1'b0;
          s2_data  <= '0;
        end else if (s1_valid) begin
          s2_valid <= 1'b1;
          s2_err   <= s1_err;
          s2_data  <= s1_data;
        end else begin
          s2_valid <= 1'b0;
          s2_err   <= 1'b0;
        end
      end

      assign inst       = s2_data;
      assign inst_valid = s2_valid;
      assign addr_err   = s2_err;
    end else begin : g_lat1
      assign inst       = s1_data;
      assign inst_valid = s1_valid;
      assign addr_err   = s1_err;
    end
  endgenerate

endmodule

// File: tb/tb_inst_mem_ld.sv
// Directed bench for inst_mem_ld. Two instances (RD_LAT=1 and RD_LAT=2) share
// the same stimulus; every cycle both are compared against a small reference
// model, and the key scenarios also carry hand-computed constant checks.
module tb_inst_mem_ld;

  localparam int          DEP   = 256;
  localparam logic [15:0] NOP_W = 16'h0BAD;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;
  logic        ld_done;
  logic        inst_req;
  logic [15:0] inst_addr;

  logic [16:0] ld_count1, ld_count2;
  logic        ld_err1, ld_err2;
  logic        run1, run2;
  logic [15:0] inst1, inst2;
  logic        inst_valid1, inst_valid2;
  logic        addr_err1, addr_err2;

  inst_mem_ld #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEP), .RD_LAT(1), .NOP(NOP_W)) u_lat1 (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done),
    .ld_count(ld_count1), .ld_err(ld_err1), .run(run1),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst(inst1), .inst_valid(inst_valid1), .addr_err(addr_err1)
  );

  inst_mem_ld #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEP), .RD_LAT(2), .NOP(NOP_W)) u_lat2 (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done),
    .ld_count(ld_count2), .ld_err(ld_err2), .run(run2),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst(inst2), .inst_valid(inst_valid2), .addr_err(addr_err2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  logic [15:0] tb_mem [DEP];
  bit          m_run;
  int          m_cnt;
  bit          m_err;
  bit          e1_v, e1_e, e2_v, e2_e;
  logic [15:0] e1_d, e2_d;

  // One clock edge; inputs are stable across it, outputs sampled 1 ns later.
  task automatic step();
    bit          acc;
    bit          oor;
    logic [15:0] rd;
    @(posedge clk);
    #1;
    acc = !rst && m_run && inst_req;
    oor = (inst_addr >= 16'(DEP));
    rd  = oor ? NOP_W : tb_mem[inst_addr[7:0]];
    if (rst) begin
      m_run = 0; m_cnt = 0; m_err = 0;
      e1_v = 0; e1_e = 0; e1_d = '0;
      e2_v = 0; e2_e = 0; e2_d = '0;
    end else begin
      if (e1_v) begin
        e2_v = 1; e2_e = e1_e; e2_d = e1_d;
      end else begin
        e2_v = 0; e2_e = 0;
      end
      if (acc) begin
        e1_v = 1; e1_e = oor; e1_d = rd;
      end else begin
        e1_v = 0; e1_e = 0;
      end
      if (!m_run) begin
        if (ld_valid) begin
          if (ld_addr < 16'(DEP)) begin
            tb_mem[ld_addr[7:0]] = ld_data;
            m_cnt++;
          end else begin
            m_err = 1;
          end
        end
        if (ld_done) m_run = 1;
      end
    end
    check("valid_lat1", inst_valid1, e1_v);
    check("aerr_lat1",  addr_err1,   e1_e);
    check("inst_lat1",  inst1,       e1_d);
    check("valid_lat2", inst_valid2, e2_v);
    check("aerr_lat2",  addr_err2,   e2_e);
    check("inst_lat2",  inst2,       e2_d);
    check("run_lat1",   run1,        m_run);
    check("run_lat2",   run2,        m_run);
    check("count_lat1", ld_count1,   m_cnt);
    check("count_lat2", ld_count2,   m_cnt);
    check("lderr_lat1", ld_err1,     m_err);
    check("lderr_lat2", ld_err2,     m_err);
  endtask

  initial begin
    rst = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    m_run = 0; m_cnt = 0; m_err = 0;
    e1_v = 0; e1_e = 0; e1_d = '0; e2_v = 0; e2_e = 0; e2_d = '0;

    // Reset for two cycles.
    step();
    step();
    check("rst_run",   run1,      1'b0);
    check("rst_count", ld_count1, 17'd0);
    check("rst_inst",  inst2,     16'h0000);

    // Load 10 words; a fetch request is held high to prove LOAD ignores it.
    rst       = 1'b0;
    inst_req  = 1'b1;
    inst_addr = 16'd3;
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1'b1;
      ld_addr  = 16'(i);
      ld_data  = 16'hA000 + 16'(i);
      step();
      check("load_gate_lat1", inst_valid1, 1'b0);
      check("load_gate_lat2", inst_valid2, 1'b0);
    end
    check("load_count", ld_count1, 17'd10);
    check("load_err",   ld_err1,   1'b0);

    // Out-of-range load write.
    ld_addr = 16'h0100;
    ld_data = 16'hBEEF;
    step();
    check("oor_ld_err",   ld_err1,   1'b1);
    check("oor_ld_count", ld_count1, 17'd10);

    // End of load.
    ld_valid = 1'b0;
    inst_req = 1'b0;
    ld_done  = 1'b1;
    step();
    ld_done = 1'b0;
    check("done_run", run1, 1'b1);
    check("done_run2", run2, 1'b1);

    // Streamed fetch of addresses 0..9.
    for (int k = 0; k < 10; k++) begin
      inst_req  = 1'b1;
      inst_addr = 16'(k);
      step();
      check("stream_lat1", inst1, 16'hA000 + 16'(k));
      check("stream_v1",   inst_valid1, 1'b1);
      if (k == 0) check("stream_first_lat2", inst_valid2, 1'b0);
      else        check("stream_lat2", inst2, 16'hA000 + 16'(k - 1));
    end
    inst_req = 1'b0;
    step();
    check("stream_tail_lat2", inst2, 16'hA009);
    check("stream_tail_v2",   inst_valid2, 1'b1);
    check("hold_lat1",        inst1, 16'hA009);
    step();
    check("hold_lat2",        inst2, 16'hA009);

    // Out-of-range fetches followed by an in-range one.
    inst_req = 1'b1; inst_addr = 16'h0100;
    step();
    check("oor_f_inst1", inst1, NOP_W);
    check("oor_f_aerr1", addr_err1, 1'b1);
    inst_addr = 16'hFFFF;
    step();
    check("oor_f_inst2", inst2, NOP_W);
    check("oor_f_aerr2", addr_err2, 1'b1);
    inst_addr = 16'h0002;
    step();
    check("inr_aerr1", addr_err1, 1'b0);
    check("inr_inst1", inst1, 16'hA002);
    inst_req = 1'b0;
    step();
    check("inr_aerr2", addr_err2, 1'b0);
    step();

    // Load port ignored in RUN.
    ld_valid = 1'b1; ld_addr = 16'h0000; ld_data = 16'h1234; ld_done = 1'b1;
    step();
    ld_valid = 1'b0; ld_done = 1'b0;
    inst_req = 1'b1; inst_addr = 16'h0000;
    step();
    check("ro_mem0_lat1", inst1, 16'hA000);
    inst_req = 1'b0;
    step();
    check("ro_mem0_lat2", inst2, 16'hA000);
    check("ro_count",     ld_count1, 17'd10);

    // Reset while two requests are in flight.
    inst_req = 1'b1; inst_addr = 16'd1;
    step();
    inst_addr = 16'd2;
    step();
    rst = 1'b1; inst_addr = 16'd3;
    step();
    check("mid_rst_v1",    inst_valid1, 1'b0);
    check("mid_rst_v2",    inst_valid2, 1'b0);
    check("mid_rst_run",   run2, 1'b0);
    check("mid_rst_count", ld_count2, 17'd0);
    rst = 1'b0; inst_req = 1'b0;
    step();
    step();
    check("post_rst_v2", inst_valid2, 1'b0);

    // Simultaneous write and ld_done.
    ld_valid = 1'b1; ld_addr = 16'd5; ld_data = 16'h5555; ld_done = 1'b1;
    step();
    ld_valid = 1'b0; ld_done = 1'b0;
    check("sim_run",   run1, 1'b1);
    check("sim_count", ld_count1, 17'd1);

    // Retained contents plus the fresh write.
    inst_req = 1'b1; inst_addr = 16'd3;
    step();
    check("retain_lat1", inst1, 16'hA003);
    inst_addr = 16'd5;
    step();
    check("sim_wr_lat1", inst1, 16'h5555);
    check("retain_lat2", inst2, 16'hA003);
    inst_req = 1'b0;
    step();
    check("sim_wr_lat2", inst2, 16'h5555);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_mem_ld.md
# inst_mem_ld

Parametrised instruction memory for the 16-bit processor. It replaces the fixed-size, always-readable instruction store with a configurable-depth array and a boot-time load port. Instruction fetch is a request/valid pipeline with selectable read latency and out-of-range detection. It sits between the program loader (testbench or boot ROM streamer) and the fetch stage of the core.

## Interface
Parameters:
- DATA_W, 16, instruction word width in bits
- ADDR_W, 16, width of the fetch and load address ports
- DEPTH, 256, number of words; 1 ≤ DEPTH ≤ 2^ADDR_W
- RD_LAT, 1, fetch latency in cycles; legal values are 1 or 2
- NOP, 16'h0000, word returned on an out-of-range fetch; DATA_W bits

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- ld_valid  in  1  load write strobe
- ld_addr  in  ADDR_W  load word address
- ld_data  in  DATA_W  load word
- ld_done  in  1  end of load; moves the block to RUN
- ld_count  out  ADDR_W+1  number of in-range words written since reset; saturates
- ld_err  out  1  sticky; set by an out-of-range load write
- run  out  1  1 while in state RUN
- inst_req  in  1  fetch request
- inst_addr  in  ADDR_W  fetch word address
- inst  out  DATA_W  fetched word
- inst_valid  out  1  inst is valid this cycle
- addr_err  out  1  qualifies inst_valid: the fetch address was ≥ DEPTH

## Operation
State machine: LOAD, RUN. Reset enters LOAD.

LOAD:
- If ld_valid=1 and ld_addr < DEPTH: write mem[ld_addr] = ld_data and increment ld_count. The counter saturates at 2^ADDR_W.
- If ld_valid=1 and ld_addr ≥ DEPTH: no write; set ld_err.
- inst_req is ignored. No response is produced and no error is flagged.
- ld_done=1 moves the state to RUN on the next edge. If ld_valid is high in the same cycle, that write is performed first.

RUN:
- ld_valid and ld_done are ignored. Memory is read-only.
- Each cycle with inst_req=1 issues one fetch. A new request may be issued every cycle, giving full throughput.
- Range check uses the full inst_addr compared against DEPTH. In-range fetches index the array with the low ceil(log2(DEPTH)) bits.
- Out-of-range fetch: inst = NOP, addr_err = 1, inst_valid = 1, at the normal latency.
- RUN is left only by reset.

Reset behaviour:
- rst=1 flushes the read pipeline and clears these registers:
  - inst_valid, addr_err, run, ld_err and ld_count go to 0
  - inst goes to 0
- Memory contents are retained and not cleared.
- rst takes priority over every other input in the same cycle.

Output holding:
- inst holds the last returned word while inst_valid=0.
- addr_err is 0 whenever inst_valid=0.

## Timing
- Load write: data is visible to a fetch issued in any cycle after the write edge. A write and a fetch to the same address cannot coincide, because LOAD and RUN are exclusive.
- ld_done sampled high at edge N: run=1 after edge N. A fetch is accepted from the cycle following edge N.
- RD_LAT=1: a request sampled at edge N gives inst, inst_valid and addr_err valid after edge N. The response is registered array output.
- RD_LAT=2: as RD_LAT=1, plus one output register stage; the response is valid after edge N+1.
- Back-to-back requests give back-to-back responses in request order. No bubbles are inserted and there is no stall input.
- Reset mid-stream: responses in flight are discarded. inst_valid=0 from the cycle after the reset edge until a new request passes through the pipeline in RUN.
- ld_count, ld_err and run update on the edge that samples the causing input.

## Test plan
- Reset then load: rst for 2 cycles, then write mem[i] = 16'hA000+i for i = 0..9, then ld_done. Required: ld_count = 10, ld_err = 0, run = 1 one cycle after ld_done.
- Streamed fetch, RD_LAT=1 and RD_LAT=2: inst_req=1 continuously, inst_addr = 0..9 one per cycle. Required: inst = 16'hA000..16'hA009 in order, inst_valid continuous, first valid 1 or 2 edges after the first request respectively.
- Out-of-range: DEPTH=256, load write to 16'h0100. Required: ld_err = 1, ld_count unchanged. In RUN, fetch 16'h0100 and 16'hFFFF. Required: inst = NOP, addr_err = 1, inst_valid = 1 at the normal latency. The next in-range fetch must show addr_err = 0.
- Mode gating: inst_req during LOAD must give no inst_valid. ld_valid to address 0 with data 16'h1234 during RUN must leave mem[0] = 16'hA000 on a later fetch.
- Reset mid-fetch: rst asserted while 2 requests are in flight (RD_LAT=2). Required: no inst_valid after the reset edge, run = 0, ld_count = 0. After re-entering RUN with no reload, a fetch of address 3 returns 16'hA003.
- Simultaneous ld_valid + ld_done (address 5, data 16'h5555): the write takes effect, then RUN. Fetching address 5 returns 16'h5555.
